// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-read-port register file.
package regfile_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int NUM_WORDS      = 2 ** DEF_ADDR_WIDTH;

    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/regfile_mrp_sb_rd_port.sv
// One read port: one-hot AND/OR select over storage with write bypass.
module rf_rd_port
    import regfile_pkg::*;
#(
    parameter int AW = DEF_ADDR_WIDTH,
    parameter int DW = DEF_DATA_WIDTH
) (
    input  logic [AW-1:0]                 rd_addr_i,
    input  logic                          wr_en_i,
    input  logic [AW-1:0]                 wr_addr_i,
    input  logic [DW-1:0]                 wr_data_i,
    input  logic [(2**AW)-1:1][DW-1:0]    mem_i,
    input  logic [(2**AW)-1:1]            pend_i,
    output logic [DW-1:0]                 rd_data_o,
    output logic                          rd_busy_o
);

    localparam int NW = 2 ** AW;

    logic          byp;
    logic [NW-1:1] sel;

    always_comb begin
        byp = wr_en_i && (wr_addr_i == rd_addr_i) && (rd_addr_i != '0);
        sel = '0;
        // Address 0 never selects, so it falls out as zero data and not busy
        for (int i = 1; i < NW; i++) begin
            sel[i] = (rd_addr_i == AW'(i)) && !byp;
        end
        rd_data_o = {DW{byp}} & wr_data_i;
        for (int i = 1; i < NW; i++) begin
            rd_data_o = rd_data_o | ({DW{sel[i]}} & mem_i[i]);
        end
        rd_busy_o = |(sel & pend_i);
    end

endmodule

// File: rtl/regfile_mrp_sb.sv
// Register file with NUM_RD read ports, bypassed write port and pending-write scoreboard.
module regfile_mrp_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_RD     = 2
) (
    input  logic                           iClk,
    input  logic                           iRst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   iRdAddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   oRdData,
    output logic [NUM_RD-1:0]              oRdBusy,
    input  logic                           iWrEn,
    input  logic [ADDR_WIDTH-1:0]          iWrAddr,
    input  logic [DATA_WIDTH-1:0]          iWrData,
    input  logic                           iRsvEn,
    input  logic [ADDR_WIDTH-1:0]          iRsvAddr,
    input  logic                           iFlush,
    output logic [(2**ADDR_WIDTH)-1:0]     oBusyVec
);

    localparam int NW = 2 ** ADDR_WIDTH;

    logic [NW-1:1][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [NW-1:1]                 pend_q, pend_d;

    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        for (int i = 1; i < NW; i++) begin
            if (iWrEn && (iWrAddr == ADDR_WIDTH'(i))) begin
                mem_d[i] = iWrData;
            end
            // A fresh reservation beats a same-cycle write clear
            if (iFlush) begin
                pend_d[i] = 1'b0;
            end else if (iRsvEn && (iRsvAddr == ADDR_WIDTH'(i))) begin
                pend_d[i] = 1'b1;
            end else if (iWrEn && (iWrAddr == ADDR_WIDTH'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            mem_q  <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    assign oBusyVec = {pend_q, 1'b0};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rf_rd_port #(
            .AW (ADDR_WIDTH),
            .DW (DATA_WIDTH)
        ) u_rd_port (
            .rd_addr_i (iRdAddr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .wr_en_i   (iWrEn),
            .wr_addr_i (iWrAddr),
            .wr_data_i (iWrData),
            .mem_i     (mem_q),
            .pend_i    (pend_q),
            .rd_data_o (oRdData[p*DATA_WIDTH +: DATA_WIDTH]),
            .rd_busy_o (oRdBusy[p])
        );
    end

endmodule
